// File: rtl/sa_pkg.sv
// ============================================================================
// Module      : sa_pkg
// Description : Shared widths, precision encodings and fusion-lane helpers
//               for the systolic MAC array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sa_pkg;

    localparam int ACT_W  = 8;
    localparam int PSUM_W = 52;
    localparam int PROD_W = 18;

    localparam logic [3:0] W2 = 4'd2;
    localparam logic [3:0] W4 = 4'd4;
    localparam logic [3:0] W8 = 4'd8;

    typedef struct packed {
        logic [3:0] iw;
        logic [3:0] ww;
        logic       s_in;
        logic       s_w;
    } mode_t;

    function automatic logic [3:0] eff_width(input logic [3:0] w);
        case (w)
            W2:      return W2;
            W4:      return W4;
            default: return W8;
        endcase
    endfunction

    // The wider operand sets how many sub-words fit into one byte.
    function automatic logic [2:0] lane_count(input logic [3:0] iw, input logic [3:0] ww);
        logic [3:0] m;
        m = (iw > ww) ? iw : ww;
        case (m)
            W2:      return 3'd4;
            W4:      return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic signed [PROD_W-1:0] lane_ext(
        input logic [ACT_W-1:0] v,
        input logic [1:0]       k,
        input logic [3:0]       w,
        input logic             s
    );
        logic [ACT_W-1:0]  sh;
        logic [ACT_W-1:0]  mask;
        logic              msb;
        logic [PROD_W-1:0] r;
        sh = v >> ({2'b00, k} * w);
        case (w)
            W2:      begin mask = 8'h03; msb = sh[1]; end
            W4:      begin mask = 8'h0F; msb = sh[3]; end
            default: begin mask = 8'hFF; msb = sh[7]; end
        endcase
        r = {{(PROD_W-ACT_W){1'b0}}, sh & mask};
        if (s && msb)
            r = r | ~{{(PROD_W-ACT_W){1'b0}}, mask};
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_pe.sv
// ============================================================================
// Module      : systolic_pe
// Description : One weight-stationary PE: fusion multiplier, activation
//               forwarding register and partial-sum register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_pe
    import sa_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  mode_t                    mode,
    input  logic [ACT_W-1:0]         weight,
    input  logic [ACT_W-1:0]         act_in,
    input  logic signed [PSUM_W-1:0] psum_in,
    output logic [ACT_W-1:0]         act_out,
    output logic signed [PSUM_W-1:0] psum_out
);

    logic [ACT_W-1:0]          r_act;
    logic signed [PSUM_W-1:0]  r_psum;
    logic [2:0]                w_lanes;
    logic signed [PROD_W-1:0]  w_a;
    logic signed [PROD_W-1:0]  w_b;
    logic signed [PROD_W-1:0]  w_p;
    logic signed [PSUM_W-1:0]  w_prod;

    // Lanes beyond the active count contribute nothing.
    always_comb begin
        w_lanes = lane_count(mode.iw, mode.ww);
        w_a     = '0;
        w_b     = '0;
        w_p     = '0;
        w_prod  = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < w_lanes) begin
                w_a    = lane_ext(act_in, 2'(k), mode.iw, mode.s_in);
                w_b    = lane_ext(weight, 2'(k), mode.ww, mode.s_w);
                w_p    = w_a * w_b;
                w_prod = w_prod + {{(PSUM_W-PROD_W){w_p[PROD_W-1]}}, w_p};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act  <= '0;
            r_psum <= '0;
        end else begin
            r_act  <= act_in;
            r_psum <= psum_in + w_prod;
        end
    end

    assign act_out  = r_act;
    assign psum_out = r_psum;

endmodule

`default_nettype wire

// File: rtl/systolic_array.sv
// ============================================================================
// Module      : systolic_array
// Description : ARRAY_SIZE x ARRAY_SIZE weight-stationary systolic MAC grid
//               with run-time 2/4/8-bit fusion precision.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_array
    import sa_pkg::*;
#(
    parameter int ARRAY_SIZE = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [3:0]                               in_width,
    input  logic [3:0]                               weight_width,
    input  logic                                     s_in,
    input  logic                                     s_weight,
    input  logic [ARRAY_SIZE*ARRAY_SIZE-1:0][ACT_W-1:0] weights,
    input  logic [ARRAY_SIZE-1:0][ACT_W-1:0]         inputs,
    output logic [ARRAY_SIZE-1:0][PSUM_W-1:0]        psums
);

    mode_t                    w_mode;
    logic [ACT_W-1:0]         w_act  [ARRAY_SIZE][ARRAY_SIZE];
    logic signed [PSUM_W-1:0] w_psum [ARRAY_SIZE+1][ARRAY_SIZE];

    assign w_mode.iw   = eff_width(in_width);
    assign w_mode.ww   = eff_width(weight_width);
    assign w_mode.s_in = s_in;
    assign w_mode.s_w  = s_weight;

    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
        assign w_act[r][0] = inputs[r];
        for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
            logic [ACT_W-1:0] w_act_o;

            systolic_pe u_pe (
                .clk      (clk),
                .rst_n    (rst_n),
                .mode     (w_mode),
                .weight   (weights[r*ARRAY_SIZE+c]),
                .act_in   (w_act[r][c]),
                .psum_in  (w_psum[r][c]),
                .act_out  (w_act_o),
                .psum_out (w_psum[r+1][c])
            );

            if (c < ARRAY_SIZE-1) begin : g_fwd
                assign w_act[r][c+1] = w_act_o;
            end else begin : g_last
                // Rightmost activations leave the array here.
                logic [ACT_W-1:0] w_act_unused;
                assign w_act_unused = w_act_o;
            end
        end
    end

    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_edge
        assign w_psum[0][c] = '0;
        assign psums[c]     = w_psum[ARRAY_SIZE][c];
    end

endmodule

`default_nettype wire

// File: tb/tb_systolic_array.sv
// ============================================================================
// Module      : tb_systolic_array
// Description : Directed self-checking bench for the systolic MAC array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_array;

    localparam int N = 8;

    logic                 clk;
    logic                 rst_n;
    logic [3:0]           in_width;
    logic [3:0]           weight_width;
    logic                 s_in;
    logic                 s_weight;
    logic [N*N-1:0][7:0]  weights;
    logic [N-1:0][7:0]    inputs;
    logic [N-1:0][51:0]   psums;

    int n_checks;
    int n_errors;

    systolic_array #(.ARRAY_SIZE(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_width     (in_width),
        .weight_width (weight_width),
        .s_in         (s_in),
        .s_weight     (s_weight),
        .weights      (weights),
        .inputs       (inputs),
        .psums        (psums)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [51:0] got, input logic [51:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic [3:0] iw, input logic [3:0] ww, input logic si, input logic sw);
        in_width     = iw;
        weight_width = ww;
        s_in         = si;
        s_weight     = sw;
    endtask

    task automatic fill(input logic [7:0] w, input logic [7:0] a);
        for (int i = 0; i < N*N; i++) weights[i] = w;
        for (int r = 0; r < N; r++) inputs[r] = a;
    endtask

    task automatic check_row(input string tag, input logic [51:0] exp);
        for (int c = 0; c < N; c++)
            check_val($sformatf("%s[%0d]", tag, c), psums[c], exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        set_mode(4'd8, 4'd8, 1'b0, 1'b0);
        for (int i = 0; i < N*N; i++) weights[i] = 8'($urandom);
        for (int r = 0; r < N; r++) inputs[r] = 8'($urandom);

        // Held in reset with random stimulus.
        tick(5);
        check_row("rst_hold", 52'd0);

        // Run, then assert reset between edges.
        fill(8'd1, 8'd1);
        #2 rst_n = 1'b1;
        tick(10);
        check_val("pre_rst_nonzero", psums[0], 52'd8);
        #2 rst_n = 1'b0;
        #1;
        check_row("rst_async", 52'd0);

        // 8b/8b unsigned, inputs r+1
        fill(8'd1, 8'd0);
        for (int r = 0; r < N; r++) inputs[r] = 8'(r + 1);
        #2 rst_n = 1'b1;
        tick(15);
        check_row("u8", 52'd36);

        // Illegal width encodings fall back to 8 bits.
        set_mode(4'd5, 4'd0, 1'b0, 1'b0);
        tick(15);
        check_row("illegal_w", 52'd36);

        set_mode(4'd8, 4'd8, 1'b1, 1'b1);
        fill(8'hFF, 8'h02);
        tick(15);
        check_row("s8", 52'hF_FFFF_FFFF_FFF0);

        set_mode(4'd4, 4'd4, 1'b0, 1'b0);
        fill(8'h33, 8'h21);
        tick(15);
        check_row("u4", 52'd72);

        set_mode(4'd2, 4'd2, 1'b0, 1'b0);
        fill(8'h55, 8'hFF);
        tick(15);
        check_row("u2", 52'd96);

        set_mode(4'd2, 4'd2, 1'b1, 1'b1);
        tick(15);
        check_row("s2", -52'sd32);

        set_mode(4'd8, 4'd4, 1'b0, 1'b0);
        fill(8'hF3, 8'h10);
        tick(15);
        check_row("mix84", 52'd384);

        // Latency from reset with a unit step.
        rst_n = 1'b0;
        set_mode(4'd8, 4'd8, 1'b0, 1'b0);
        fill(8'd1, 8'd0);
        tick(2);
        for (int r = 0; r < N; r++) inputs[r] = 8'd1;
        #2 rst_n = 1'b1;
        tick(7);
        check_val("lat_c0_e7", psums[0], 52'd7);
        check_val("lat_c7_e7", psums[N-1], 52'd0);
        tick(1);
        check_val("lat_c0_e8", psums[0], 52'd8);
        tick(6);
        check_val("lat_c7_e14", psums[N-1], 52'd7);
        tick(1);
        check_val("lat_c7_e15", psums[N-1], 52'd8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
